// File: rtl/dqn_pkg.sv
// Shared DQN accelerator definitions: datapath defaults, phase codes and bias-update FSM states.
package dqn_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned FRAC_W       = 10;
    localparam int unsigned DEF_LR_SHIFT = 5;

    localparam logic [3:0] CTRL_DELTA = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        APPLY,
        DONE
    } bu_state_e;

endpackage

// File: rtl/bias_sat_sub.sv
// Combinational bias - (delta >>> LR_SHIFT) at DATA_W+1 bits.
// BIAS_UPDATE_SAT_EN selects clamping on overflow; otherwise the result wraps.
module bias_sat_sub #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LR_SHIFT = 5
) (
    input  logic signed [DATA_W-1:0] bias,
    input  logic signed [DATA_W-1:0] delta,
    output logic signed [DATA_W-1:0] result
);

    logic signed [DATA_W-1:0] scaled;
    logic signed [DATA_W:0]   diff;

    // Arithmetic shift rounds toward minus infinity.
    assign scaled = delta >>> LR_SHIFT;
    assign diff   = {bias[DATA_W-1], bias} - {scaled[DATA_W-1], scaled};

`ifdef BIAS_UPDATE_SAT_EN
    always_comb begin
        result = diff[DATA_W-1:0];
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            result = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign result = diff[DATA_W-1:0];
`endif

endmodule

// File: rtl/bias_update.sv
// Backward-pass bias update: collect N_NEURON deltas in the delta phase, then apply them
// one bias per cycle. Overflow behaviour selected by BIAS_UPDATE_SAT_EN (see bias_sat_sub).
module bias_update
    import dqn_pkg::*;
#(
    parameter int unsigned N_NEURON = 4,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned LR_SHIFT = DEF_LR_SHIFT,
    parameter int unsigned AW       = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               step,
    input  logic [3:0]               controller,
    input  logic                     delta_valid,
    input  logic signed [DATA_W-1:0] delta,
    output logic                     delta_ready,
    input  logic [AW-1:0]            bias_raddr,
    output logic signed [DATA_W-1:0] bias_rdata,
    output logic                     busy,
    output logic                     done
);

    localparam logic [AW:0] N_LIM = (AW + 1)'(N_NEURON);

    bu_state_e                state;
    logic [AW-1:0]            idx;
    logic signed [DATA_W-1:0] bias [N_NEURON];
    logic signed [DATA_W-1:0] dbuf [N_NEURON];
    logic signed [DATA_W-1:0] new_bias;
    logic                     phase_ok;
    logic                     accept;
    logic                     last_idx;

    assign phase_ok    = (controller == CTRL_DELTA) && (step != 4'd0);
    assign delta_ready = (state == COLLECT);
    assign busy        = (state == COLLECT) || (state == APPLY);
    assign accept      = delta_valid && delta_ready;
    assign last_idx    = (idx == AW'(N_NEURON - 1));

    bias_sat_sub #(
        .DATA_W   (DATA_W),
        .LR_SHIFT (LR_SHIFT)
    ) u_sub (
        .bias   (bias[idx]),
        .delta  (dbuf[idx]),
        .result (new_bias)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            done       <= 1'b0;
            bias_rdata <= '0;
            for (int i = 0; i < int'(N_NEURON); i++) begin
                bias[i] <= '0;
                dbuf[i] <= '0;
            end
        end else begin
            done       <= 1'b0;
            // Sampled before this cycle's write, so a same-address update reads the old value.
            bias_rdata <= ({1'b0, bias_raddr} < N_LIM) ? bias[bias_raddr] : '0;
            case (state)
                IDLE: begin
                    if (phase_ok) begin
                        state <= COLLECT;
                        idx   <= '0;
                    end
                end
                COLLECT: begin
                    // Abort takes priority over a coincident accept.
                    if (!phase_ok) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else if (accept) begin
                        dbuf[idx] <= delta;
                        if (last_idx) begin
                            idx   <= '0;
                            state <= APPLY;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                APPLY: begin
                    bias[idx] <= new_bias;
                    if (last_idx) begin
                        idx   <= '0;
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                DONE: begin
                    // Hold until the phase ends so one phase yields one update.
                    if (controller != CTRL_DELTA) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bias_update.sv
// Directed self-checking bench for bias_update; expectations follow BIAS_UPDATE_SAT_EN.
module tb_bias_update;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        step;
    logic [3:0]        controller;
    logic              delta_valid;
    logic signed [15:0] delta;
    logic              delta_ready;
    logic [1:0]        bias_raddr;
    logic signed [15:0] bias_rdata;
    logic              busy;
    logic              done;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    always #5 clk = ~clk;

    bias_update dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .controller  (controller),
        .delta_valid (delta_valid),
        .delta       (delta),
        .delta_ready (delta_ready),
        .bias_raddr  (bias_raddr),
        .bias_rdata  (bias_rdata),
        .busy        (busy),
        .done        (done)
    );

    // Full update with fixed timing; counts done pulses, leaves the block in IDLE.
    task automatic run_update(input logic [15:0] d [4]);
        controller  = 4'd9;
        step        = 4'd1;
        delta_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            delta       = d[i];
            delta_valid = 1'b1;
            @(negedge clk);
            if (done) pulses++;
        end
        delta_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        controller = 4'd0;
        @(negedge clk);
        if (done) pulses++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, delta_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, delta_ready});
        end
        rst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bias_raddr = 2'(a);
            @(negedge clk);
            vectors++;
            if (bias_rdata !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_bias%0d: got %h expected 0000", a, bias_rdata);
            end
        end
        vectors++;
        if ({busy, done, delta_ready} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle: got %b expected 000", {busy, done, delta_ready});
        end
    endtask

    task automatic test_basic();
        logic [15:0] d [4];
        logic [15:0] exp [4];
        int done_at;
        int npulse;
        int extra;
        d   = '{16'h0400, 16'hFC00, 16'h0020, 16'hFFFF};
        exp = '{16'hFFE0, 16'h0020, 16'hFFFF, 16'h0001};
        controller = 4'd9;
        step       = 4'd1;
        @(negedge clk);
        vectors++;
        if (delta_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_ready: got %b expected 1", delta_ready);
        end
        for (int i = 0; i < 4; i++) begin
            delta       = d[i];
            delta_valid = 1'b1;
            @(negedge clk);
        end
        delta_valid = 1'b0;
        vectors++;
        if ({busy, delta_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_apply: got busy/ready %b expected 10", {busy, delta_ready});
        end
        done_at = 0;
        npulse  = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                npulse++;
                if (done_at == 0) done_at = k;
            end
        end
        vectors++;
        if (done_at !== 5 || npulse !== 1) begin
            miscompares++;
            $display("FAIL basic_done: got at %0d x%0d expected at 5 x1", done_at, npulse);
        end
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL basic_no_second: got %0d active cycles expected 0", extra);
        end
        for (int a = 0; a < 4; a++) begin
            bias_raddr = 2'(a);
            @(negedge clk);
            vectors++;
            if (bias_rdata !== exp[a]) begin
                miscompares++;
                $display("FAIL basic_bias%0d: got %h expected %h", a, bias_rdata, exp[a]);
            end
        end
        controller = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_gating();
        int seen;
        controller = 4'd9;
        step       = 4'd0;
        seen       = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (delta_ready || busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL gating_step0: got %0d ready cycles expected 0", seen);
        end
        controller = 4'd0;
        step       = 4'd1;
        @(negedge clk);
    endtask

    task automatic test_abort();
        logic [15:0] exp [4];
        logic [15:0] d [4];
        int npulse;
        exp = '{16'hFFE0, 16'h0020, 16'hFFFF, 16'h0001};
        controller = 4'd9;
        step       = 4'd1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            delta       = 16'h7FFF;
            delta_valid = 1'b1;
            @(negedge clk);
        end
        controller = 4'd0;
        delta      = 16'h4000;
        @(negedge clk);
        delta_valid = 1'b0;
        vectors++;
        if ({busy, delta_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_idle: got busy/ready %b expected 00", {busy, delta_ready});
        end
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        vectors++;
        if (npulse !== 0) begin
            miscompares++;
            $display("FAIL abort_done: got %0d pulses expected 0", npulse);
        end
        for (int a = 0; a < 4; a++) begin
            bias_raddr = 2'(a);
            @(negedge clk);
            vectors++;
            if (bias_rdata !== exp[a]) begin
                miscompares++;
                $display("FAIL abort_bias%0d: got %h expected %h", a, bias_rdata, exp[a]);
            end
        end
        // A fresh update after abort must start from neuron 0.
        d   = '{16'h0020, 16'h0020, 16'h0020, 16'h0020};
        exp = '{16'hFFDF, 16'h001F, 16'hFFFE, 16'h0000};
        pulses = 0;
        run_update(d);
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL abort_retry_done: got %0d pulses expected 1", pulses);
        end
        for (int a = 0; a < 4; a++) begin
            bias_raddr = 2'(a);
            @(negedge clk);
            vectors++;
            if (bias_rdata !== exp[a]) begin
                miscompares++;
                $display("FAIL abort_retry_bias%0d: got %h expected %h", a, bias_rdata, exp[a]);
            end
        end
    endtask

    task automatic test_reset_mid_apply();
        int npulse;
        controller = 4'd9;
        step       = 4'd1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            delta       = 16'h0400;
            delta_valid = 1'b1;
            @(negedge clk);
        end
        delta_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({busy, done, bias_rdata} !== 18'h0) begin
            miscompares++;
            $display("FAIL midreset_async: got busy %b done %b rdata %h expected 0 0 0000",
                     busy, done, bias_rdata);
        end
        controller = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        vectors++;
        if (npulse !== 0) begin
            miscompares++;
            $display("FAIL midreset_done: got %0d pulses expected 0", npulse);
        end
        for (int a = 0; a < 4; a++) begin
            bias_raddr = 2'(a);
            @(negedge clk);
            vectors++;
            if (bias_rdata !== 16'h0000) begin
                miscompares++;
                $display("FAIL midreset_bias%0d: got %h expected 0000", a, bias_rdata);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d [4];
        logic [15:0] exp;
`ifdef BIAS_UPDATE_SAT_EN
        exp = 16'h7FFF;
`else
        exp = 16'h8400;
`endif
        d      = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        pulses = 0;
        for (int n = 0; n < 33; n++) run_update(d);
        vectors++;
        if (pulses !== 33) begin
            miscompares++;
            $display("FAIL overflow_done: got %0d pulses expected 33", pulses);
        end
        for (int a = 0; a < 4; a++) begin
            bias_raddr = 2'(a);
            @(negedge clk);
            vectors++;
            if (bias_rdata !== exp) begin
                miscompares++;
                $display("FAIL overflow_bias%0d: got %h expected %h", a, bias_rdata, exp);
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        step        = 4'd0;
        controller  = 4'd0;
        delta_valid = 1'b0;
        delta       = 16'h0000;
        bias_raddr  = 2'd0;
        test_reset();
        test_basic();
        test_gating();
        test_abort();
        test_reset_mid_apply();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bias_update.md
# bias_update

Bias-update engine for the backward pass of the DQN accelerator. It accepts the per-neuron error deltas of one layer while the controller is in the delta phase (`controller == 9`, `step != 0`), buffers them, and scales each by the learning rate 2^-LR_SHIFT (default 0.03125). It then subtracts each scaled value from its stored bias, one bias per cycle. It also provides the registered bias read port used by the forward-pass datapath.

## Interface
Parameters:
- `N_NEURON`, default 4: number of biases and deltas per update.
- `DATA_W`, default 16: signed fixed-point width, Q6.10.
- `LR_SHIFT`, default 5: learning-rate exponent; the scaled delta is `delta >>> LR_SHIFT`.
- `AW`, default `$clog2(N_NEURON)`: address width.

Ports:
- `clk` — input, 1 — single clock; all logic on the rising edge.
- `rst` — input, 1 — asynchronous, active-low reset.
- `step` — input, 4 — training step; 0 means no training.
- `controller` — input, 4 — global phase code; 9 is the delta phase.
- `delta_valid` — input, 1 — delta word present.
- `delta` — input, DATA_W, signed — error delta, Q6.10, in neuron order 0..N_NEURON-1.
- `delta_ready` — output, 1 — block accepts a delta this cycle.
- `bias_raddr` — input, AW — forward-pass read address.
- `bias_rdata` — output, DATA_W, signed — registered bias read data.
- `busy` — output, 1 — high in COLLECT or APPLY.
- `done` — output, 1 — one-cycle pulse when all biases are updated.

## Operation
- Storage:
  - `bias[N_NEURON]` register bank.
  - `dbuf[N_NEURON]` delta buffer.
  - Index counter `idx`, width AW.
- IDLE:
  - `delta_ready` = 0.
  - Moves to COLLECT when `controller == 9 && step != 0`; `idx` is cleared to 0.
- COLLECT:
  - `delta_ready` = 1.
  - Each cycle with `delta_valid && delta_ready`, the block writes `dbuf[idx] <= delta` and increments `idx`.
  - When the accept at `idx == N_NEURON-1` occurs, it clears `idx` and moves to APPLY.
- Abort:
  - If `controller != 9` or `step == 0` in any COLLECT cycle, the block returns to IDLE.
  - The buffer is discarded and the bias bank is unchanged.
  - If abort and accept happen in the same cycle, abort wins and the delta is dropped.
- APPLY:
  - Lasts exactly N_NEURON cycles; `delta_ready` = 0.
  - Each cycle writes `bias[idx] <= bias[idx] - (dbuf[idx] >>> LR_SHIFT)`, then increments `idx`.
  - Phase inputs are ignored, so the update is never partial except on reset.
- DONE:
  - `done` = 1 on the first cycle only.
  - The block stays in DONE until `controller != 9`, then goes to IDLE. This prevents a double update within one phase.
- Arithmetic:
  - The shift is arithmetic and rounds toward −∞; for example, −1 >>> 5 = −1.
  - The subtraction is computed at DATA_W+1 bits, then reduced to DATA_W bits as described under Configuration.
- Read port:
  - `bias_rdata <= bias[bias_raddr]` every cycle, in every state.
  - It returns the pre-write value when the same address is written in that cycle.
  - Out-of-range addresses (≥ N_NEURON) return 0.

## Timing
- Reset values (async assert, synchronous release): all `bias` = 0, `dbuf` = 0, `idx` = 0, state = IDLE. Outputs: `bias_rdata` = 0, `delta_ready` = 0, `busy` = 0, `done` = 0.
- Phase latency: phase conditions true at edge t gives `delta_ready` = 1 in cycle t+1.
- Update latency: the last delta accepted at edge t gives APPLY in cycles t+1..t+N_NEURON, and `done` high in cycle t+N_NEURON+1.
- Read latency: 1 cycle from `bias_raddr` to `bias_rdata`.
- Throughput: one delta per cycle; the total update costs 2·N_NEURON+1 cycles minimum.
- Reset asserted mid-APPLY: the bank clears immediately and any partial update is lost.

## Configuration
- `BIAS_UPDATE_SAT_EN` defined: an out-of-range result clamps to `+0x7FFF` / `-0x8000` (for DATA_W = 16).
- `BIAS_UPDATE_SAT_EN` undefined: the low DATA_W bits are kept (two's-complement wrap).

## Structure
- Shared package `dqn_pkg`:
  - Defaults for DATA_W, FRAC_W = 10, and LR_SHIFT.
  - Constant `CTRL_DELTA = 4'd9`.
  - State enum `{IDLE, COLLECT, APPLY, DONE}`.
- One sub-module, `bias_sat_sub`: a combinational subtract-with-scale that contains the `BIAS_UPDATE_SAT_EN` logic.

## Test plan
- Reset: hold `rst` = 0, then release and read addresses 0..3 → `bias_rdata` = 0 for each; `busy` = `done` = 0; `delta_ready` = 0.
- Basic update:
  - Stimulus: `controller` = 9, `step` = 1, deltas `0x0400`, `0xFC00`, `0x0020`, `0xFFFF`.
  - Required response: `done` pulses once, 5 cycles after the last accept.
  - Required biases: `0xFFE0`, `0x0020`, `0xFFFF`, `0x0001`.
- Gating:
  - `controller` = 9 with `step` = 0 for 10 cycles → `delta_ready` stays 0.
  - `controller` held at 9 after `done` → no second update.
- Abort: `controller` drops to 0 after 2 deltas are accepted → IDLE next cycle, biases unchanged, no `done` pulse.
- Overflow: 33 consecutive updates with all deltas `0x8000`.
  - With `BIAS_UPDATE_SAT_EN`: bias 0 reads `0x7FFF`.
  - Without it: bias 0 reads `0x8400`.
- Reset mid-APPLY: assert `rst` = 0 on the 2nd APPLY cycle → all biases read 0 after release; `done` never pulses.
